psimd_sat_alu: RTL and testbench

//  Parametrised, pipelined packed-SIMD saturating add/sub unit for the EX stage.

---
 rtl/psimd_sat_alu.sv | 123 ++++++++++++
 tb/tb_psimd_sat_alu.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psimd_sat_alu.sv
// ============================================================================
//  Module      : psimd_sat_alu
//  Description : Two-stage packed-SIMD saturating add/sub unit (uadd/usub/
//                sadd/ssub per lane) with valid/ready flow and sticky status.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module psimd_sat_alu #(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic [1:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [WIDTH/LANE_W-1:0]   out_sat,
  input  logic                      clr_sat,
  output logic                      sat_sticky
);

  localparam int c_NLANE = WIDTH / LANE_W;
  localparam int c_MSB   = LANE_W - 1;

  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_s1_a;
  logic [WIDTH-1:0]     r_s1_b;
  logic [1:0]           r_s1_op;

  logic                 w_adv1;
  logic                 w_adv2;
  logic                 w_deliver;
  logic [WIDTH-1:0]     w_res;
  logic [c_NLANE-1:0]   w_sat;

  assign w_adv2    = !out_valid || out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign in_ready  = w_adv1;
  assign w_deliver = out_valid && out_ready;

  for (genvar i = 0; i < c_NLANE; i++) begin : g_lane
    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_b;
    logic [LANE_W:0]   w_sum;
    logic              w_sovf;
    logic [LANE_W-1:0] w_lane_res;
    logic              w_lane_sat;

    assign w_a   = r_s1_a[i*LANE_W +: LANE_W];
    assign w_b   = r_s1_b[i*LANE_W +: LANE_W];
    // The extra top bit is the unsigned carry (add) or borrow (sub).
    assign w_sum = r_s1_op[0] ? ({1'b0, w_a} - {1'b0, w_b})
                              : ({1'b0, w_a} + {1'b0, w_b});
    assign w_sovf = r_s1_op[1]
                  && (r_s1_op[0] ? (w_a[c_MSB] != w_b[c_MSB]) : (w_a[c_MSB] == w_b[c_MSB]))
                  && (w_sum[c_MSB] != w_a[c_MSB]);

    always_comb begin
      w_lane_res = w_sum[LANE_W-1:0];
      w_lane_sat = 1'b0;
      if (!r_s1_op[1] && w_sum[LANE_W]) begin
        w_lane_res = r_s1_op[0] ? {LANE_W{1'b0}} : {LANE_W{1'b1}};
        w_lane_sat = 1'b1;
      end else if (w_sovf) begin
        w_lane_res = w_a[c_MSB] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        w_lane_sat = 1'b1;
      end
    end

    assign w_res[i*LANE_W +: LANE_W] = w_lane_res;
    assign w_sat[i]                  = w_lane_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= 2'b00;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
        r_s1_op <= in_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (w_adv2) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data <= w_res;
        out_sat  <= w_sat;
      end
    end
  end

  // A saturating delivery takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
    end else if (w_deliver && |out_sat) begin
      sat_sticky <= 1'b1;
    end else if (clr_sat) begin
      sat_sticky <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_psimd_sat_alu.sv
// ============================================================================
//  Module      : tb_psimd_sat_alu
//  Description : Self-checking bench for psimd_sat_alu (16/4 and 32/8 builds).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_psimd_sat_alu;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int N  = W / L;
  localparam int W2 = 32;
  localparam int L2 = 8;
  localparam int N2 = W2 / L2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, out_ready = 1'b1, clr_sat = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [1:0]    in_op = 2'b00;
  logic          in_ready, out_valid, sat_sticky;
  logic [W-1:0]  out_data;
  logic [N-1:0]  out_sat;

  logic          b_in_valid = 1'b0;
  logic [W2-1:0] b_in_a = '0, b_in_b = '0;
  logic [1:0]    b_in_op = 2'b00;
  logic          b_in_ready, b_out_valid, b_sat_sticky;
  logic [W2-1:0] b_out_data;
  logic [N2-1:0] b_out_sat;

  psimd_sat_alu #(.WIDTH(W), .LANE_W(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .clr_sat(clr_sat), .sat_sticky(sat_sticky)
  );

  psimd_sat_alu #(.WIDTH(W2), .LANE_W(L2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op), .out_valid(b_out_valid),
    .out_ready(1'b1), .out_data(b_out_data), .out_sat(b_out_sat),
    .clr_sat(1'b0), .sat_sticky(b_sat_sticky)
  );

  int             n_cmp = 0;
  int             n_bad = 0;
  logic [W+N-1:0] exp_q[$];
  logic           exp_sticky = 1'b0;
  logic           held_v = 1'b0;
  logic [W+N:0]   held = '0;
  logic           last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane-wise reference: exact integer result clamped to the lane's range.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [1:0] op, input int lw, input int nl,
                                output logic [63:0] r, output logic [7:0] s);
    logic [63:0] mask;
    mask = (64'd1 << lw) - 64'd1;
    r = '0;
    s = '0;
    for (int i = 0; i < nl; i++) begin
      longint ua, ub, sa, sb, v, lo, hi, half;
      logic [63:0] ures;
      half = longint'(1) << (lw - 1);
      ua = longint'((a >> (i * lw)) & mask);
      ub = longint'((b >> (i * lw)) & mask);
      sa = (ua >= half) ? ua - 2 * half : ua;
      sb = (ub >= half) ? ub - 2 * half : ub;
      if (op[1]) begin
        lo = -half;
        hi = half - 1;
        v  = op[0] ? sa - sb : sa + sb;
      end else begin
        lo = 0;
        hi = 2 * half - 1;
        v  = op[0] ? ua - ub : ua + ub;
      end
      if (v > hi) begin
        v = hi; s[i] = 1'b1;
      end else if (v < lo) begin
        v = lo; s[i] = 1'b1;
      end
      ures = v;
      r = r | ((ures & mask) << (i * lw));
    end
  endfunction

  // One clock: sample handshakes at the falling edge, update the scoreboard,
  // then return 1 time unit after the next rising edge.
  task automatic cyc();
    logic [W+N-1:0] e;
    logic [63:0]    r;
    logic [7:0]     s;
    logic           del, nxt;
    #4;
    last_acc = in_valid && in_ready;
    del      = out_valid && out_ready;
    if (held_v) check("hold_stable", {out_valid, out_sat, out_data}, held);
    held_v = out_valid && !out_ready;
    held   = {out_valid, out_sat, out_data};
    nxt    = exp_sticky;
    if (clr_sat) nxt = 1'b0;
    if (del) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[W-1:0]);
        check("out_sat", out_sat, e[W+N-1:W]);
        if (|e[W+N-1:W]) nxt = 1'b1;
      end
    end
    if (last_acc) begin
      model(64'(in_a), 64'(in_b), in_op, L, N, r, s);
      exp_q.push_back({s[N-1:0], r[W-1:0]});
    end
    @(posedge clk);
    #1;
    exp_sticky = nxt;
    check("sticky", sat_sticky, exp_sticky);
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  logic [63:0] r32;
  logic [7:0]  s32;

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_sat", out_sat, '0);
    check("rst_sticky", sat_sticky, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Reference vectors and two-cycle latency
    beat(16'h9A4C, 16'h8B57, 2'b00);
    cyc();
    in_valid = 1'b0;
    check("lat_n1", out_valid, 1'b0);
    cyc();
    check("lat_n2", out_valid, 1'b1);
    check("uadd_data", out_data, 16'hFF9F);
    check("uadd_sat", out_sat, 4'b1101);
    beat(16'h783F, 16'h1F2F, 2'b10);
    cyc();
    beat(16'h1234, 16'h2222, 2'b01);
    cyc();
    in_valid = 1'b0;
    check("sadd_data", out_data, 16'h785E);
    check("sadd_sat", out_sat, 4'b1100);
    cyc();
    check("usub_data", out_data, 16'h0012);
    check("usub_sat", out_sat, 4'b1000);
    cyc();

    // Sticky: stalled result does not set; clear loses to a coincident set
    clr_sat = 1'b1;
    cyc();
    clr_sat   = 1'b0;
    out_ready = 1'b0;
    beat(16'hFFFF, 16'h0001, 2'b00);
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    check("stall_no_sticky", sat_sticky, 1'b0);
    out_ready = 1'b1;
    clr_sat   = 1'b1;
    cyc();
    check("set_beats_clr", sat_sticky, 1'b1);
    cyc();
    check("clr_alone", sat_sticky, 1'b0);
    clr_sat = 1'b0;

    // Backpressure: two beats fill the pipe, third waits
    out_ready = 1'b0;
    beat(W'($urandom), W'($urandom), 2'($urandom));
    cyc();
    beat(W'($urandom), W'($urandom), 2'($urandom));
    cyc();
    beat(W'($urandom), W'($urandom), 2'($urandom));
    check("bp_in_ready", in_ready, 1'b0);
    cyc();
    cyc();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_stream", out_valid, 1'b1);
      cyc();
      if (last_acc) in_valid = 1'b0;
    end
    check("bp_empty", out_valid, 1'b0);

    // Reset with both stages full
    out_ready = 1'b0;
    beat(16'hFFFF, 16'hFFFF, 2'b00);
    cyc();
    cyc();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_sticky", sat_sticky, 1'b0);
    check("rst_mid_ready", in_ready, 1'b1);
    exp_q.delete();
    exp_sticky = 1'b0;
    held_v     = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_valid", out_valid, 1'b0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    beat(16'h0F0F, 16'h0101, 2'b11);
    cyc();
    in_valid = 1'b0;
    check("rst_lat_n1", out_valid, 1'b0);
    cyc();
    check("rst_lat_n2", out_valid, 1'b1);
    cyc();

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_sat   = ($urandom_range(0, 9) == 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_op     = 2'($urandom);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_sat   = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) cyc();
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_valid", out_valid, 1'b0);

    // 32-bit build with 8-bit lanes
    b_in_valid = 1'b1;
    b_in_a = 32'h11223380; b_in_b = 32'h01010101; b_in_op = 2'b11;
    @(posedge clk);
    #1;
    b_in_a = 32'h7F00FF80; b_in_b = 32'h01000180; b_in_op = 2'b10;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    check("w32_ssub_valid", b_out_valid, 1'b1);
    check("w32_ssub_data", b_out_data, 32'h10213280);
    check("w32_ssub_sat", b_out_sat, 4'b0001);
    model(64'h11223380, 64'h01010101, 2'b11, L2, N2, r32, s32);
    check("w32_ssub_model", b_out_data, r32);
    @(posedge clk);
    #1;
    check("w32_sadd_data", b_out_data, 32'h7F000080);
    check("w32_sadd_sat", b_out_sat, 4'b1001);
    model(64'h7F00FF80, 64'h01000180, 2'b10, L2, N2, r32, s32);
    check("w32_sadd_model_sat", 64'(b_out_sat), 64'(s32[N2-1:0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
